// File: rtl/user_obi_reader.sv
// user_obi_reader: OBI read manager that fetches a block of consecutive 32-bit words
// and streams them out over a valid/ready interface. One transaction outstanding, reads only.
//
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   start_i         start pulse, sampled only when idle
//   base_addr_i     first byte address (bits [1:0] ignored)
//   num_words_i     number of words to read (0 completes at once)
//   busy_o          high whenever not idle
//   done_o          one-cycle completion pulse
//   err_o           sticky bus-error flag, cleared by an accepted start
//   data_o          read word, data_valid_o qualifies it, data_ready_i accepts it
//   obi_req_o       OBI A channel request
//   obi_rsp_i       OBI grant and R channel response
//
// The OBI struct types and address/data/id widths come from user_obi_reader_pkg below.

package user_obi_reader_pkg;
  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiIdWidth   = 1;

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [ObiDataWidth/8-1:0] be;
    logic [ObiDataWidth-1:0]   wdata;
    logic [ObiIdWidth-1:0]     aid;
    logic                      a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic [ObiIdWidth-1:0]   rid;
    logic                    err;
    logic                    r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } obi_rsp_t;
endpackage

module user_obi_reader #(
  parameter type         obi_req_t = user_obi_reader_pkg::obi_req_t,
  parameter type         obi_rsp_t = user_obi_reader_pkg::obi_rsp_t,
  parameter int unsigned CntWidth  = 8
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        start_i,
  input  logic [user_obi_reader_pkg::ObiAddrWidth-1:0] base_addr_i,
  input  logic [CntWidth-1:0]                         num_words_i,
  output logic                                        busy_o,
  output logic                                        done_o,
  output logic                                        err_o,
  output logic [31:0]                                 data_o,
  output logic                                        data_valid_o,
  input  logic                                        data_ready_i,
  output obi_req_t                                    obi_req_o,
  input  obi_rsp_t                                    obi_rsp_i
);
  localparam int unsigned AddrWidth = user_obi_reader_pkg::ObiAddrWidth;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StOut,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [CntWidth-1:0]   remaining_q, remaining_d;
  logic [31:0]           data_q, data_d;
  logic                  err_q, err_d;

  // Response id, optional bits and the byte offset of the base address play no role.
  logic unused_bits;
  assign unused_bits = ^{base_addr_i[1:0], obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d      = {base_addr_i[AddrWidth-1:2], 2'b00};
          remaining_d = num_words_i;
          err_d       = 1'b0;
          state_d     = (num_words_i == '0) ? StDone : StReq;
        end
      end
      StReq: begin
        if (obi_rsp_i.gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            data_d  = obi_rsp_i.r.rdata;
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (data_ready_i) begin
          addr_d      = addr_q + AddrWidth'(4);
          remaining_d = remaining_q - CntWidth'(1);
          state_d     = (remaining_q == CntWidth'(1)) ? StDone : StReq;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    obi_req_o        = '0;
    // Address is driven continuously from the register so it cannot move while waiting for gnt.
    obi_req_o.a.addr = addr_q;
    if (state_q == StReq) begin
      obi_req_o.req  = 1'b1;
      obi_req_o.a.be = '1;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign data_valid_o = (state_q == StOut);
  assign data_o       = data_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_user_obi_reader.sv
module tb_user_obi_reader;
  import user_obi_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [7:0]  num_words_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i;
  obi_req_t    obi_req_o;
  obi_rsp_t    obi_rsp_i;

  user_obi_reader #(
    .CntWidth(8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_words_i (num_words_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i),
    .obi_req_o   (obi_req_o),
    .obi_rsp_i   (obi_rsp_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Model: the list of addresses and words a transfer must produce, derived from base/count/error.
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] got_addr_q[$];
  logic [31:0] got_data_q[$];
  bit          exp_err;
  int          done_cnt   = 0;
  int          req_cycles = 0;

  // Subordinate / consumer behaviour knobs.
  int gnt_delay    = 0;
  int ready_delay  = 0;
  int rvalid_delay = 1;
  int err_idx      = -1;
  int gnt_idx      = 0;

  task automatic load_model(input logic [31:0] base, input int n, input int eidx);
    int ntr;
    logic [31:0] a;
    exp_addr_q.delete();
    exp_data_q.delete();
    got_addr_q.delete();
    got_data_q.delete();
    exp_err = (eidx >= 0) && (eidx < n);
    ntr     = exp_err ? eidx + 1 : n;
    a       = base & 32'hFFFF_FFFC;
    for (int i = 0; i < ntr; i++) begin
      exp_addr_q.push_back(a);
      if (!(exp_err && i == eidx)) exp_data_q.push_back(mem_word(a));
      a = a + 32'd4;
    end
    err_idx = eidx;
    gnt_idx = 0;
  endtask

  // Subordinate and consumer, driven on the falling edge.
  initial begin
    bit          last_req = 1'b0, last_valid = 1'b0, pend = 1'b0, pend_err = 1'b0;
    logic [31:0] last_addr = '0, pend_addr = '0;
    int          pend_cnt = 0, wait_cnt = 0, vcnt = 0;
    obi_rsp_i    = '0;
    data_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (last_req && obi_rsp_i.gnt) begin
        pend      = 1'b1;
        pend_cnt  = rvalid_delay - 1;
        pend_addr = last_addr;
        pend_err  = (gnt_idx == err_idx);
        gnt_idx++;
      end
      if (last_valid && data_ready_i) vcnt = 0;
      obi_rsp_i.rvalid = 1'b0;
      obi_rsp_i.r      = '0;
      if (pend) begin
        if (pend_cnt == 0) begin
          obi_rsp_i.rvalid  = 1'b1;
          obi_rsp_i.r.rdata = pend_err ? 32'hDEAD_BEEF : mem_word(pend_addr);
          obi_rsp_i.r.err   = pend_err;
          pend              = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      obi_rsp_i.gnt = 1'b0;
      if (obi_req_o.req) begin
        if (wait_cnt >= gnt_delay) begin
          obi_rsp_i.gnt = 1'b1;
          wait_cnt      = 0;
        end else begin
          wait_cnt++;
        end
      end
      data_ready_i = 1'b0;
      if (data_valid_o) begin
        if (vcnt >= ready_delay) data_ready_i = 1'b1;
        else vcnt++;
      end
      last_req   = obi_req_o.req;
      last_addr  = obi_req_o.a.addr;
      last_valid = data_valid_o;
    end
  end

  // Compare process: checks every cycle against the model, 1 time unit after the falling edge.
  initial begin
    bit          stall_req = 1'b0, stall_valid = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_i) begin
        stall_req   = 1'b0;
        stall_valid = 1'b0;
        continue;
      end
      if (stall_req) begin
        check("req_held_until_gnt", obi_req_o.req, 1'b1);
        check("a_addr_stable", obi_req_o.a.addr, prev_addr);
      end
      if (obi_req_o.req) begin
        req_cycles++;
        check("a_fields", {obi_req_o.a.we, obi_req_o.a.be, obi_req_o.a.wdata, obi_req_o.a.aid,
                           obi_req_o.a.a_optional}, {1'b0, 4'hF, 32'h0, 1'b0, 1'b0});
        if (obi_rsp_i.gnt) begin
          check("req_expected", exp_addr_q.size() != 0, 1'b1);
          if (exp_addr_q.size() != 0) check("a_addr", obi_req_o.a.addr, exp_addr_q.pop_front());
          got_addr_q.push_back(obi_req_o.a.addr);
        end
        stall_req = !obi_rsp_i.gnt;
        prev_addr = obi_req_o.a.addr;
      end else begin
        stall_req = 1'b0;
      end
      if (stall_valid) begin
        check("valid_held", data_valid_o, 1'b1);
        check("data_held", data_o, prev_data);
      end
      if (data_valid_o) begin
        if (!stall_valid) begin
          check("data_expected", exp_data_q.size() != 0, 1'b1);
          if (exp_data_q.size() != 0) check("data", data_o, exp_data_q[0]);
        end
        if (data_ready_i) begin
          got_data_q.push_back(data_o);
          if (exp_data_q.size() != 0) void'(exp_data_q.pop_front());
        end
        stall_valid = !data_ready_i;
        prev_data   = data_o;
      end else begin
        stall_valid = 1'b0;
      end
      if (obi_req_o.req || data_valid_o || done_o) check("busy_active", busy_o, 1'b1);
      if (done_o) begin
        done_cnt++;
        check("done_all_addr", exp_addr_q.size(), 0);
        check("done_all_data", exp_data_q.size(), 0);
        check("done_err", err_o, exp_err);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Leaves the bench in cycle t+1 where t is the edge that samples start_i.
  task automatic start_cmd(input logic [31:0] base, input int n, input int eidx);
    load_model(base, n, eidx);
    step();
    start_i     = 1'b1;
    base_addr_i = base;
    num_words_i = 8'(n);
    step();
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int k;
    for (k = 0; k < 2000 && !done_o; k++) step();
    check({name, "_done_seen"}, done_o, 1'b1);
    step();
    check({name, "_idle_after_done"}, {busy_o, done_o}, 2'b00);
    check({name, "_one_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0, r0;
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int d0, r0;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    base_addr_i = '0;
    num_words_i = '0;
    step();
    step();
    check("rst_req", obi_req_o, '0);
    check("rst_flags", {busy_o, done_o, err_o, data_valid_o}, 4'b0000);
    check("rst_data", data_o, 32'h0);
    rst_i = 1'b0;
    step();

    // Zero-wait read of two words with cycle-exact timing.
    d0 = done_cnt;
    start_cmd(32'h0, 2, -1);
    check("t1_req_t1", {obi_req_o.req, obi_req_o.a.addr}, {1'b1, 32'h0});
    step();
    check("t1_wait_t2", {obi_req_o.req, data_valid_o, busy_o}, 3'b001);
    step();
    check("t1_valid_t3", {data_valid_o, data_o}, {1'b1, 32'h1000_0000});
    step();
    check("t1_req_t4", {obi_req_o.req, obi_req_o.a.addr}, {1'b1, 32'h4});
    wait_done("t1", d0);
    check("t1_addr1", got_addr_q[1], 32'h4);
    check("t1_data", {got_data_q[0], got_data_q[1]}, {32'h1000_0000, 32'h1000_0001});
    check("t1_err", err_o, 1'b0);

    // Unaligned base.
    d0 = done_cnt;
    start_cmd(32'h7, 1, -1);
    check("t2_a", {obi_req_o.req, obi_req_o.a.addr, obi_req_o.a.we, obi_req_o.a.be},
          {1'b1, 32'h4, 1'b0, 4'hF});
    wait_done("t2", d0);
    check("t2_ndata", got_data_q.size(), 1);
    check("t2_data", got_data_q[0], 32'h1000_0001);

    // Zero-length transfer.
    d0 = done_cnt;
    r0 = req_cycles;
    start_cmd(32'h40, 0, -1);
    check("t3_done_t1", {done_o, busy_o, obi_req_o.req}, 3'b110);
    wait_done("t3", d0);
    check("t3_no_req", req_cycles - r0, 0);

    // Slow grant and slow consumer.
    gnt_delay   = 3;
    ready_delay = 4;
    d0 = done_cnt;
    start_cmd(32'h100, 3, -1);
    wait_done("t4", d0);
    check("t4_ndata", got_data_q.size(), 3);
    check("t4_addr0", got_addr_q[0], 32'h100);
    check("t4_data2", got_data_q[2], 32'h1000_0042);
    gnt_delay   = 0;
    ready_delay = 0;

    // Bus error on the second read.
    d0 = done_cnt;
    start_cmd(32'h20, 4, 1);
    wait_done("t5", d0);
    check("t5_ndata", got_data_q.size(), 1);
    check("t5_data0", got_data_q[0], 32'h1000_0008);
    check("t5_nreq", got_addr_q.size(), 2);
    check("t5_err_held", err_o, 1'b1);
    d0 = done_cnt;
    start_cmd(32'h0, 1, -1);
    check("t5_err_cleared", err_o, 1'b0);
    wait_done("t5b", d0);

    // Reset while waiting for the response, with a late rvalid.
    rvalid_delay = 2;
    start_cmd(32'h40, 2, -1);
    step();
    check("t6_in_wait", {obi_req_o.req, busy_o, data_valid_o}, 3'b010);
    rst_i = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    step();
    check("t6_rst_req", obi_req_o, '0);
    check("t6_rst_flags", {busy_o, done_o, err_o, data_valid_o}, 4'b0000);
    check("t6_rst_data", data_o, 32'h0);
    rst_i = 1'b0;
    step();
    check("t6_late_rvalid_ignored", {busy_o, data_valid_o, data_o}, {2'b00, 32'h0});
    rvalid_delay = 1;
    step();
    d0 = done_cnt;
    start_cmd(32'hFFFF_FFFC, 2, -1);
    wait_done("t6", d0);
    check("t6_addrs", {got_addr_q[0], got_addr_q[1]}, {32'hFFFF_FFFC, 32'h0});
    check("t6_data", {got_data_q[0], got_data_q[1]}, {32'h4FFF_FFFF, 32'h1000_0000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
